// File: rtl/mux_8x1_rr_arbiter_if.sv
// Bus bundle between the requesters and the round-robin mux arbiter.
// The requester side (master) drives req/din. The arbiter side (slave) returns
// the grant, the mux select and the forwarded data beat.
interface mux_8x1_rr_arbiter_if #(
  parameter int W = 8
);
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [7:0]     gnt;
  logic [2:0]     sel;
  logic           busy;
  logic [W-1:0]   dout;
  logic           dout_valid;

  modport master (
    output req, din,
    input  gnt, sel, busy, dout, dout_valid
  );

  modport slave (
    input  req, din,
    output gnt, sel, busy, dout, dout_valid
  );
endinterface

// File: rtl/mux_8x1_rr_arbiter.sv
// Round-robin arbiter and select controller for a shared 8:1 data mux.
// One lane owns the mux at a time, for up to MAX_BURST beats per tenure.
// On release the arbiter re-arbitrates in the same edge, so there is no idle
// bubble between back-to-back owners. The current owner is searched last.
module mux_8x1_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  mux_8x1_rr_arbiter_if.slave    bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [2:0]   last;
  logic [3:0]   cnt;
  logic [7:0]   gnt_q;
  logic [2:0]   sel_q;
  logic         busy_q;
  logic [W-1:0] dout_q;
  logic         dv_q;

  logic [2:0]   ptr;
  logic [2:0]   cand;
  logic         win_found;
  logic [2:0]   win_idx;
  logic         beat;
  logic         rel_now;
  logic [W-1:0] din_lane;

  // Round-robin search starting just after the pointer. While granting, the pointer is the current owner, so the owner is considered last.
  always_comb begin
    ptr       = (state == GRANT) ? sel_q : last;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = ptr;
    for (int i = 8; i >= 1; i--) begin
      cand = ptr + 3'(i);
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // A beat happens whenever the owner keeps its request up. The tenure ends on a dropped request or on the final allowed beat.
  always_comb begin
    beat     = bus.req[sel_q];
    rel_now  = !beat || (cnt == 4'(MAX_BURST - 1));
    din_lane = bus.din[sel_q*W +: W];
  end

  // Arbitration FSM, with grant, select and the forwarded data all registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      sel_q  <= '0;
      busy_q <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      cnt    <= '0;
      last   <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          dv_q <= 1'b0;
          if (win_found) begin
            state  <= GRANT;
            sel_q  <= win_idx;
            gnt_q  <= 8'(8'b1 << win_idx);
            busy_q <= 1'b1;
            cnt    <= '0;
          end
        end
        GRANT: begin
          dv_q <= beat;
          if (beat) begin
            dout_q <= din_lane;
          end
          if (rel_now) begin
            last <= sel_q;
            cnt  <= '0;
            if (win_found) begin
              sel_q <= win_idx;
              gnt_q <= 8'(8'b1 << win_idx);
            end else begin
              state  <= IDLE;
              gnt_q  <= '0;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          dv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;

endmodule

// File: tb/tb_mux_8x1_rr_arbiter.sv
// Self-checking bench for mux_8x1_rr_arbiter. The reference model tracks the
// owner lane, the beats used in the tenure and the round-robin pointer as plain
// integers. Directed scenarios also carry hand-derived constant expectations.
module tb_mux_8x1_rr_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_8x1_rr_arbiter_if #(.W(W)) bus ();

  mux_8x1_rr_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         m_owner;
  int         m_used;
  int         m_last;
  int         m_sel;
  logic       m_dv;
  logic [7:0] m_dout;

  function automatic int pick(logic [7:0] r, int ptr);
    for (int k = 1; k <= 8; k++) begin
      if (r[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  task automatic m_step();
    if (!rst_n) begin
      m_owner = -1; m_used = 0; m_last = 7; m_sel = 0; m_dv = 1'b0; m_dout = 8'h00;
    end else if (m_owner < 0) begin
      m_dv = 1'b0;
      if (bus.req != 8'h00) begin
        m_owner = pick(bus.req, m_last);
        m_sel   = m_owner;
        m_used  = 0;
      end
    end else begin
      if (bus.req[m_owner]) begin
        m_dv   = 1'b1;
        m_dout = bus.din[m_owner*8 +: 8];
        m_used = m_used + 1;
      end else begin
        m_dv = 1'b0;
      end
      if (!bus.req[m_owner] || m_used == MB) begin
        m_last  = m_owner;
        m_owner = pick(bus.req, m_last);
        m_used  = 0;
        if (m_owner >= 0) m_sel = m_owner;
      end
    end
  endtask

  function automatic logic [20:0] exp_vec();
    logic [7:0] g;
    g = (m_owner < 0) ? 8'h00 : 8'(8'h01 << m_owner);
    return {g, 3'(m_sel), (m_owner >= 0), m_dv, m_dout};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {bus.gnt, bus.sel, bus.busy, bus.dout_valid, bus.dout};
  endfunction

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 8'h00; bus.din = '0;
    repeat (5) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL reset_model: got %h expected %h", obs_vec(), exp_vec());
      end
      checks++;
      if (obs_vec() !== 21'h0) begin
        errors++; $display("[TB] FAIL reset_zero: got %h expected 0", obs_vec());
      end
    end
    rst_n = 1'b1;
    repeat (3) begin
      cycle();
      checks++;
      if (obs_vec() !== 21'h0) begin
        errors++; $display("[TB] FAIL idle_no_req: got %h expected 0", obs_vec());
      end
    end
  endtask

  task automatic test_single_lane();
    bus.req = 8'h08;
    bus.din = '0;
    bus.din[3*8 +: 8] = 8'h30;
    for (int k = 0; k <= 12; k++) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL single_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      checks++;
      if (bus.gnt !== 8'h08) begin
        errors++; $display("[TB] FAIL single_gnt k=%0d: got %h expected 08", k, bus.gnt);
      end
      if (k >= 1) begin
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'(8'h30 + k - 1)) begin
          errors++; $display("[TB] FAIL single_data k=%0d: got dv=%b dout=%h expected dv=1 dout=%h",
                             k, bus.dout_valid, bus.dout, 8'(8'h30 + k - 1));
        end
        bus.din[3*8 +: 8] = 8'(8'h30 + k);
      end
    end
    bus.req = 8'h00;
    repeat (2) begin
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL single_release: got %h expected %h", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_all_lanes();
    rst_n = 1'b0; bus.req = 8'h00;
    cycle();
    rst_n = 1'b1; bus.req = 8'hFF;
    for (int k = 1; k <= 34; k++) begin
      bus.din = {$urandom, $urandom};
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL all_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      checks++;
      if (bus.sel !== 3'(((k - 1) / MB) % 8) || bus.gnt !== 8'(8'h01 << (((k - 1) / MB) % 8))) begin
        errors++; $display("[TB] FAIL all_seq k=%0d: got sel=%0d gnt=%h expected sel=%0d",
                           k, bus.sel, bus.gnt, ((k - 1) / MB) % 8);
      end
      if (k >= 2) begin
        checks++;
        if (bus.dout_valid !== 1'b1) begin
          errors++; $display("[TB] FAIL all_valid k=%0d: got %b expected 1", k, bus.dout_valid);
        end
      end
    end
  endtask

  task automatic test_drop();
    rst_n = 1'b0; bus.req = 8'h00;
    cycle();
    rst_n = 1'b1; bus.req = 8'h20;
    cycle();
    checks++;
    if (bus.gnt !== 8'h20) begin
      errors++; $display("[TB] FAIL drop_first: got %h expected 20", bus.gnt);
    end
    bus.req = 8'h22;
    repeat (2) begin
      bus.din = {$urandom, $urandom};
      cycle();
      checks++;
      if (obs_vec() !== exp_vec() || bus.gnt !== 8'h20 || bus.dout_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL drop_beats: got %h expected %h", obs_vec(), exp_vec());
      end
    end
    bus.req = 8'h02;
    cycle();
    checks++;
    if (bus.gnt !== 8'h02 || bus.busy !== 1'b1 || bus.dout_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_switch: got gnt=%h busy=%b dv=%b expected gnt=02 busy=1 dv=0",
                         bus.gnt, bus.busy, bus.dout_valid);
    end
    bus.din = {$urandom, $urandom};
    cycle();
    checks++;
    if (obs_vec() !== exp_vec() || bus.dout_valid !== 1'b1 || bus.dout !== bus.din[1*8 +: 8]) begin
      errors++; $display("[TB] FAIL drop_next_beat: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; bus.req = 8'h00;
    cycle();
    rst_n = 1'b1; bus.req = 8'h80;
    cycle();
    bus.req = 8'h81;
    repeat (MB) cycle();
    checks++;
    if (bus.gnt !== 8'h01 || obs_vec() !== exp_vec()) begin
      errors++; $display("[TB] FAIL wrap_lane0: got gnt=%h expected 01", bus.gnt);
    end
    repeat (MB) cycle();
    checks++;
    if (bus.gnt !== 8'h80 || obs_vec() !== exp_vec()) begin
      errors++; $display("[TB] FAIL wrap_lane7: got gnt=%h expected 80", bus.gnt);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0; bus.req = 8'h00;
    cycle();
    rst_n = 1'b1; bus.req = 8'h04;
    repeat (3) begin
      bus.din = {$urandom, $urandom} | 64'h0000_0000_0001_0000;
      cycle();
    end
    checks++;
    if (bus.gnt !== 8'h04 || bus.dout_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL midrst_pre: got gnt=%h dv=%b expected gnt=04 dv=1", bus.gnt, bus.dout_valid);
    end
    rst_n = 1'b0;
    cycle();
    checks++;
    if (obs_vec() !== 21'h0) begin
      errors++; $display("[TB] FAIL midrst_abort: got %h expected 0", obs_vec());
    end
    rst_n = 1'b1; bus.req = 8'hFF;
    cycle();
    checks++;
    if (bus.gnt !== 8'h01 || bus.sel !== 3'd0) begin
      errors++; $display("[TB] FAIL midrst_regrant: got gnt=%h sel=%0d expected gnt=01 sel=0", bus.gnt, bus.sel);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
      bus.din = {$urandom, $urandom};
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL random_model k=%0d: got %h expected %h", k, obs_vec(), exp_vec());
      end
      checks++;
      if (!$onehot0(bus.gnt) || bus.busy !== (bus.gnt != 8'h00)) begin
        errors++; $display("[TB] FAIL random_invariant k=%0d: got gnt=%h busy=%b", k, bus.gnt, bus.busy);
      end
    end
  endtask

  // Runs every scenario in order, then prints the summary line.
  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; bus.req = 8'h00; bus.din = '0;
    m_owner = -1; m_used = 0; m_last = 7; m_sel = 0; m_dv = 1'b0; m_dout = 8'h00;
    test_reset();
    test_single_lane();
    test_all_lanes();
    test_drop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
